// File: rtl/cpu_io_port_if.sv
// rtl/cpu_io_port_if.sv - CPU start/capture and host drain signal bundle for cpu_io_port.
interface cpu_io_port_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  logic                    startIO;
  logic                    outFlag;
  logic [WIDTH-1:0]        out;
  logic                    start_req;
  logic                    stop_req;
  logic                    host_valid;
  logic                    host_ready;
  logic [WIDTH-1:0]        host_data;
  logic [$clog2(DEPTH):0]  count;
  logic                    overflow;
  logic                    busy;
  logic                    host_parity;

  modport master (
    output startIO,
    input  outFlag,
    input  out,
    input  start_req,
    input  stop_req,
    output host_valid,
    input  host_ready,
    output host_data,
    output count,
    output overflow,
    output busy,
    output host_parity
  );

  modport slave (
    input  startIO,
    output outFlag,
    output out,
    output start_req,
    output stop_req,
    input  host_valid,
    output host_ready,
    input  host_data,
    input  count,
    input  overflow,
    input  busy,
    input  host_parity
  );
endinterface

// File: rtl/cpu_io_port.sv
// rtl/cpu_io_port.sv - CPU start-pulse sequencer with output-capture FIFO drained by the host.
// Optional CPU_IO_PORT_PARITY_EN keeps a parity bit per FIFO entry and drives host_parity.
module cpu_io_port #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 8,
  parameter int START_CYCLES = 4
) (
  input  logic          clock,
  input  logic          reset,
  cpu_io_port_if.master bus
);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int PCW = $clog2(START_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, START, RUN} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [PCW-1:0]   r_pulse;
  logic [PCW-1:0]   w_pulse_next;
  logic             w_clr_ovf;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW-1:0]    w_rptr_next;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_head;
  logic             r_overflow;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic             w_head_from_rd;
  logic             w_head_from_in;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_pulse <= '0;
    end else begin
      r_state <= w_state_next;
      r_pulse <= w_pulse_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pulse_next = r_pulse;
    w_clr_ovf    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start_req) begin
          w_state_next = START;
          w_pulse_next = PCW'(START_CYCLES);
          w_clr_ovf    = 1'b1;
        end
      end
      START: begin
        if (r_pulse <= PCW'(1)) begin
          w_state_next = RUN;
          w_pulse_next = '0;
        end else begin
          w_pulse_next = r_pulse - PCW'(1);
        end
      end
      RUN: begin
        if (bus.stop_req) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign bus.startIO = (r_state == START);
  assign bus.busy    = (r_state != IDLE);

  assign w_full      = (r_count == CW'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_pop       = !w_empty && bus.host_ready;
  assign w_push      = (r_state == RUN) && bus.outFlag && (!w_full || w_pop);
  assign w_drop      = (r_state == RUN) && bus.outFlag && w_full && !w_pop;
  assign w_rptr_next = r_rptr + PW'(1);

  // Head register refills from the next stored entry on a pop, or takes the incoming
  // word directly when the FIFO is (or is becoming) empty.
  assign w_head_from_rd = w_pop && (r_count > CW'(1));
  assign w_head_from_in = w_push && (w_empty || (w_pop && (r_count == CW'(1))));

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= bus.out;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_head     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= w_rptr_next;
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      if (w_head_from_rd)      r_head <= r_mem[w_rptr_next];
      else if (w_head_from_in) r_head <= bus.out;
      if (w_clr_ovf)   r_overflow <= 1'b0;
      else if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign bus.host_valid = !w_empty;
  assign bus.host_data  = r_head;
  assign bus.count      = r_count;
  assign bus.overflow   = r_overflow;

`ifdef CPU_IO_PORT_PARITY_EN
  logic r_pmem [DEPTH];
  logic r_head_par;

  always_ff @(posedge clock) begin
    if (w_push) r_pmem[r_wptr] <= ^bus.out;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_head_par <= 1'b0;
    end else if (w_head_from_rd) begin
      r_head_par <= r_pmem[w_rptr_next];
    end else if (w_head_from_in) begin
      r_head_par <= ^bus.out;
    end
  end

  assign bus.host_parity = r_head_par;
`else
  assign bus.host_parity = 1'b0;
`endif
endmodule

// File: doc/cpu_io_port.md
CPU_IO_PORT -- requirements
Module: cpu_io_port

Interface
- REQ-001 The block SHALL have parameter WIDTH, default 32, the CPU output word width.
- REQ-002 The block SHALL have parameter DEPTH, default 8, the capture FIFO depth; it SHALL be a power of two and at least 2.
- REQ-003 The block SHALL have parameter START_CYCLES, default 4, the startIO pulse length in cycles, at least 1.
- REQ-004 The block SHALL have port clock, input, 1 bit: single clock, all state updates on its rising edge.
- REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
- REQ-006 The block SHALL have port startIO, output, 1 bit: start strobe to the CPU.
- REQ-007 The block SHALL have port outFlag, input, 1 bit: CPU output-valid flag.
- REQ-008 The block SHALL have port out, input, WIDTH bits: CPU output word.
- REQ-009 The block SHALL have port start_req, input, 1 bit: host request to start a run.
- REQ-010 The block SHALL have port stop_req, input, 1 bit: host request to end a run.
- REQ-011 The block SHALL have port host_valid, output, 1 bit: FIFO head is valid.
- REQ-012 The block SHALL have port host_ready, input, 1 bit: host accepts the head word.
- REQ-013 The block SHALL have port host_data, output, WIDTH bits: FIFO head word.
- REQ-014 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: FIFO occupancy.
- REQ-015 The block SHALL have port overflow, output, 1 bit: sticky flag, a CPU word was dropped.
- REQ-016 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
- REQ-017 The block SHALL have port host_parity, output, 1 bit: parity of host_data (see Configuration).

Function
- REQ-018 The block SHALL implement the states IDLE, START and RUN.
- REQ-019 In IDLE, when start_req is 1, the block SHALL go to START and load the pulse counter with START_CYCLES.
- REQ-020 The block SHALL hold startIO at 1 for exactly START_CYCLES consecutive cycles while in START, then go to RUN; startIO SHALL be 0 in every other state.
- REQ-021 In RUN, when stop_req is 1, the block SHALL go to IDLE on the next edge; start_req SHALL be ignored outside IDLE.
- REQ-022 When start_req and stop_req are both 1, stop_req SHALL take priority in RUN; in IDLE, start_req SHALL be honoured.
- REQ-023 A push SHALL occur on each rising edge where the state is RUN, outFlag=1, and either the FIFO is not full or a pop occurs in the same cycle.
- REQ-024 outFlag SHALL be ignored in IDLE and in START.
- REQ-025 A pop SHALL occur on each edge where host_valid=1 and host_ready=1.
- REQ-026 host_data SHALL change only on a pop, or on a push into an empty FIFO.
- REQ-027 A word pushed into an empty FIFO SHALL appear on host_data with host_valid=1 in the cycle after the push edge (latency 1).
- REQ-028 host_valid SHALL equal (count != 0).
- REQ-029 Draining SHALL continue in every state, including IDLE.
- REQ-030 A push and a pop in the same cycle SHALL leave count unchanged; when the FIFO is full this SHALL store the new word.
- REQ-031 When the FIFO is full, outFlag=1 in RUN and no pop occurs, the word SHALL be dropped and overflow SHALL be set to 1.
- REQ-032 overflow SHALL be cleared only by reset or by entering START.
- REQ-033 When the FIFO is empty, host_ready SHALL have no effect and count SHALL never go below 0.
- REQ-034 The read and write pointers SHALL be $clog2(DEPTH) bits and SHALL wrap from DEPTH-1 to 0.
- REQ-035 count SHALL range from 0 to DEPTH inclusive.

Reset
- REQ-036 Asserting reset (low), at any time including mid-run or mid-pulse, SHALL immediately force the state to IDLE.
- REQ-037 Reset SHALL immediately force startIO=0, busy=0, count=0, host_valid=0, overflow=0, host_data=0 and both pointers to 0.
- REQ-038 FIFO storage contents SHALL not need to be reset.
- REQ-039 On release of reset, the first state transition SHALL occur on the first rising edge with reset=1.

Configuration
- REQ-040 Macro CPU_IO_PORT_PARITY_EN SHALL select the host_parity behaviour.
- REQ-041 With CPU_IO_PORT_PARITY_EN defined, host_parity SHALL be the XOR reduction of host_data, combinational and valid whenever host_valid=1.
- REQ-042 With CPU_IO_PORT_PARITY_EN defined, a parity register SHALL be stored alongside each FIFO entry.
- REQ-043 Without CPU_IO_PORT_PARITY_EN, host_parity SHALL be constant 0, no parity storage SHALL exist, and all other behaviour SHALL be identical.

Verification
- REQ-044 Start pulse: reset released, start_req=1 for 1 cycle -> startIO high for exactly 4 cycles, then busy=1 in RUN.
- REQ-045 Capture/drain: in RUN with host_ready=0, push 0x11, 0x22, 0x33 -> count=3; then host_ready=1 -> host_data 0x11, 0x22, 0x33 in order, count returns to 0.
- REQ-046 Full boundary: with host_ready=0, push 9 words 0..8 with DEPTH=8 -> count=8, overflow=1, and drain yields 0..7.
- REQ-047 Full plus simultaneous pop: with the FIFO full, outFlag=1 and host_ready=1 in the same cycle -> count stays 8 and overflow stays 0.
- REQ-048 Reset mid-run: 5 words queued, reset pulsed low between clock edges -> all outputs 0 immediately and state IDLE.
- REQ-049 Parity with the macro defined: push 0x00000007 -> host_parity=1; push 0x00000003 -> host_parity=0.
